// File: rtl/cpc_ram1m_ctrl_pkg.sv
// Shared definitions for the 1MB CPC RAM expansion controller.
// Covers the mode encodings, the port data tag and the slot-to-block mapping.
package cpc_ram_pkg;

  typedef enum logic [2:0] {
    MODE0 = 3'd0,
    MODE1 = 3'd1,
    MODE2 = 3'd2,
    MODE3 = 3'd3,
    MODE4 = 3'd4,
    MODE5 = 3'd5,
    MODE6 = 3'd6,
    MODE7 = 3'd7
  } cfg_mode_e;

  localparam logic [1:0] PORT_DATA_TAG = 2'b11;

  // Returns {is_exp, blk[1:0]}; blk is zero whenever the slot stays on internal DRAM.
  function automatic logic [2:0] map_slot(input logic [2:0] mode, input logic [1:0] slot);
    logic [2:0] r;
    r = 3'b000;
    case (cfg_mode_e'(mode))
      MODE1, MODE3: if (slot == 2'd3) r = 3'b111;
      MODE2:        r = {1'b1, slot};
      MODE4, MODE5, MODE6, MODE7: if (slot == 2'd1) r = {1'b1, mode[1:0]};
      default:      r = 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cpc_ram1m_ctrl_cfg_port.sv
// Decodes &7Fxx configuration writes and holds the bank/mode register.
// Captures once per I/O cycle, on the rising edge of the qualified write strobe.
module cpc_cfg_port
  import cpc_ram_pkg::*;
#(
  parameter int unsigned BANK_BITS = 4,
  parameter logic        PORT_A15  = 1'b0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [15:0]          i_a,
  input  logic [7:0]           i_d,
  input  logic                 i_ioreq_b,
  input  logic                 i_wr_b,
  input  logic                 i_m1_b,
  output logic [2:0]           o_cfg_mode,
  output logic [BANK_BITS-1:0] o_cfg_bank
);

  logic                 r_io_wr_q;
  logic [2:0]           r_cfg_mode;
  logic [BANK_BITS-1:0] r_cfg_bank;
  logic                 w_io_wr;
  logic [5:0]           w_bank_raw;
  logic                 w_unused;

  assign w_io_wr = !i_ioreq_b && !i_wr_b && i_m1_b && (i_a[15] == PORT_A15) &&
                   (i_d[7:6] == PORT_DATA_TAG);
  // Upper bank bits come inverted from A[5:3], as on the original board.
  assign w_bank_raw = {~i_a[5:3], i_d[5:3]};
  assign w_unused   = ^{i_a[14:6], i_a[2:0]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_io_wr_q  <= 1'b0;
      r_cfg_mode <= 3'd0;
      r_cfg_bank <= '0;
    end else begin
      r_io_wr_q <= w_io_wr;
      if (w_io_wr && !r_io_wr_q) begin
        r_cfg_mode <= i_d[2:0];
        r_cfg_bank <= w_bank_raw[BANK_BITS-1:0];
      end
    end
  end

  assign o_cfg_mode = r_cfg_mode;
  assign o_cfg_bank = r_cfg_bank;

endmodule

// File: rtl/cpc_ram1m_ctrl.sv
// Top of the 1MB CPC RAM expansion controller: maps CPU accesses onto two 512K SRAMs.
// Memory-side outputs are combinational from the registered config and the live strobes.
module cpc_ram1m_ctrl
  import cpc_ram_pkg::*;
#(
  parameter int unsigned BANK_BITS = 4,
  parameter logic        PORT_A15  = 1'b0
) (
  input  logic        CLK,
  input  logic        RESET_B,
  input  logic [15:0] A,
  input  logic [7:0]  D,
  input  logic        MREQ_B,
  input  logic        IOREQ_B,
  input  logic        RD_B,
  input  logic        WR_B,
  input  logic        RFSH_B,
  input  logic        M1_B,
  input  logic        ROMEN_B,
  input  logic [3:0]  dip,
  output logic        RAMDIS,
  output logic [4:0]  HIADR,
  output logic        RAMCS0_B,
  output logic        RAMCS1_B,
  output logic        RAMOE_B,
  output logic        RAMWE_B,
  output logic [7:0]  gpio
);

  logic [2:0]           w_cfg_mode;
  logic [BANK_BITS-1:0] w_cfg_bank;
  logic [2:0]           w_map;
  logic [BANK_BITS+1:0] w_phys;
  logic                 w_hit;
  logic                 w_sel;
  logic                 w_unused;

  cpc_cfg_port #(
    .BANK_BITS (BANK_BITS),
    .PORT_A15  (PORT_A15)
  ) u_cfg_port (
    .i_clk      (CLK),
    .i_rst_n    (RESET_B),
    .i_a        (A),
    .i_d        (D),
    .i_ioreq_b  (IOREQ_B),
    .i_wr_b     (WR_B),
    .i_m1_b     (M1_B),
    .o_cfg_mode (w_cfg_mode),
    .o_cfg_bank (w_cfg_bank)
  );

  assign w_map  = map_slot(w_cfg_mode, A[15:14]);
  assign w_phys = {w_cfg_bank, w_map[1:0]};
  // 6128 hosts already own bank 0 internally, so dip[1] masks it.
  assign w_hit  = dip[0] && w_map[2] && !(dip[1] && (w_cfg_bank == '0));
  // IOREQ wins over a simultaneous MREQ; refresh and ROM reads never reach SRAM.
  assign w_sel  = w_hit && !MREQ_B && IOREQ_B && RFSH_B && ROMEN_B;

  assign RAMDIS   = w_sel;
  assign HIADR    = w_phys[4:0];
  assign RAMCS0_B = !(w_sel && !w_phys[5]);
  assign RAMCS1_B = !(w_sel && w_phys[5]);
  assign RAMOE_B  = !(w_sel && !RD_B);
  assign RAMWE_B  = !(w_sel && !WR_B);
  assign gpio     = 8'({w_cfg_bank, w_cfg_mode});

  assign w_unused = ^{dip[3:2], w_phys[BANK_BITS+1:6 > BANK_BITS+1 ? BANK_BITS+1 : 5]};

endmodule

// File: tb/tb_cpc_ram1m_ctrl.sv
// Directed self-checking bench for cpc_ram1m_ctrl with hand-computed vectors.
// Memory outputs are packed as {RAMDIS, CS0_B, CS1_B, OE_B, WE_B, HIADR}.
module tb_cpc_ram1m_ctrl;

  logic        CLK = 1'b0;
  logic        RESET_B;
  logic [15:0] A;
  logic [7:0]  D;
  logic        MREQ_B, IOREQ_B, RD_B, WR_B, RFSH_B, M1_B, ROMEN_B;
  logic [3:0]  dip;
  logic        RAMDIS, RAMCS0_B, RAMCS1_B, RAMOE_B, RAMWE_B;
  logic [4:0]  HIADR;
  logic [7:0]  gpio;

  int n_vec = 0;
  int n_err = 0;

  cpc_ram1m_ctrl dut (
    .CLK      (CLK),
    .RESET_B  (RESET_B),
    .A        (A),
    .D        (D),
    .MREQ_B   (MREQ_B),
    .IOREQ_B  (IOREQ_B),
    .RD_B     (RD_B),
    .WR_B     (WR_B),
    .RFSH_B   (RFSH_B),
    .M1_B     (M1_B),
    .ROMEN_B  (ROMEN_B),
    .dip      (dip),
    .RAMDIS   (RAMDIS),
    .HIADR    (HIADR),
    .RAMCS0_B (RAMCS0_B),
    .RAMCS1_B (RAMCS1_B),
    .RAMOE_B  (RAMOE_B),
    .RAMWE_B  (RAMWE_B),
    .gpio     (gpio)
  );

  always #5 CLK = ~CLK;

  function automatic logic [9:0] mem_vec();
    return {RAMDIS, RAMCS0_B, RAMCS1_B, RAMOE_B, RAMWE_B, HIADR};
  endfunction

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    MREQ_B = 1'b1; IOREQ_B = 1'b1; RD_B = 1'b1; WR_B = 1'b1;
    RFSH_B = 1'b1; M1_B = 1'b1; ROMEN_B = 1'b1;
  endtask

  task automatic io_out(input logic [15:0] addr, input logic [7:0] data);
    @(negedge CLK);
    A = addr; D = data; IOREQ_B = 1'b0; WR_B = 1'b0;
    @(negedge CLK);
    bus_idle();
    @(negedge CLK);
  endtask

  // Single memory access probe; rd/wr select the strobe, rom drives ROMEN_B low.
  task automatic mem_chk(input string tag, input logic [15:0] addr, input logic rd,
                         input logic wr, input logic rom, input logic [9:0] exp);
    @(negedge CLK);
    A = addr; MREQ_B = 1'b0; RD_B = !rd; WR_B = !wr; ROMEN_B = !rom;
    #1;
    chk(tag, mem_vec(), exp);
    bus_idle();
  endtask

  initial begin
    RESET_B = 1'b0; A = 16'h0000; D = 8'h00; dip = 4'b0001;
    bus_idle();
    #1;
    chk("reset_mem", mem_vec(), 10'b0_1_1_1_1_00000);
    chk("reset_gpio", 10'(gpio), 10'h000);
    #20;
    RESET_B = 1'b1;

    mem_chk("m0_rd_c000", 16'hC000, 1, 0, 0, 10'b0_1_1_1_1_00000);
    chk("m0_gpio", 10'(gpio), 10'h000);

    io_out(16'h7FFF, 8'hC1);
    chk("m1_gpio", 10'(gpio), 10'h001);
    mem_chk("m1_rd_c000", 16'hC000, 1, 0, 0, 10'b1_0_1_0_1_00011);
    mem_chk("m1_wr_c000", 16'hC000, 0, 1, 0, 10'b1_0_1_1_0_00011);
    mem_chk("m1_rom_rd", 16'hC000, 1, 0, 1, 10'b0_1_1_1_1_00011);
    dip = 4'b0000;
    mem_chk("m1_dip_off", 16'hC000, 1, 0, 0, 10'b0_1_1_1_1_00011);
    dip = 4'b0001;

    io_out(16'h7FF7, 8'hFE);
    chk("m6_gpio", 10'(gpio), 10'h07E);
    mem_chk("m6_wr_4000", 16'h4000, 0, 1, 0, 10'b1_1_0_1_0_11110);
    mem_chk("m6_rd_8000", 16'h8000, 1, 0, 0, 10'b0_1_1_1_1_11100);
    @(negedge CLK);
    A = 16'h4000; MREQ_B = 1'b0; IOREQ_B = 1'b0; RD_B = 1'b0;
    #1;
    chk("ioreq_wins", mem_vec(), 10'b0_1_1_1_1_11110);
    bus_idle();

    // Long I/O cycle: D changes after the capture edge and must not be re-latched.
    @(negedge CLK);
    A = 16'h7FFF; D = 8'hC2; IOREQ_B = 1'b0; WR_B = 1'b0;
    @(negedge CLK);
    D = 8'hC3;
    @(negedge CLK);
    @(negedge CLK);
    bus_idle();
    @(negedge CLK);
    chk("single_capture", 10'(gpio), 10'h002);
    io_out(16'h7FFF, 8'h8A);
    chk("ga_write_ignored", 10'(gpio), 10'h002);
    io_out(16'hFFFF, 8'hC5);
    chk("a15_high_ignored", 10'(gpio), 10'h002);
    mem_chk("m2_rd_0000", 16'h0000, 1, 0, 0, 10'b1_0_1_0_1_00000);
    mem_chk("m2_rd_8000", 16'h8000, 1, 0, 0, 10'b1_0_1_0_1_00010);
    dip = 4'b0011;
    mem_chk("6128_bank0", 16'h0000, 1, 0, 0, 10'b0_1_1_1_1_00000);
    dip = 4'b0001;

    io_out(16'h7FFF, 8'hCA);
    chk("b1_gpio", 10'(gpio), 10'h00A);
    mem_chk("b1_rd_4000", 16'h4000, 1, 0, 0, 10'b1_0_1_0_1_00101);
    @(negedge CLK);
    A = 16'h4000; MREQ_B = 1'b0; RFSH_B = 1'b0;
    #1;
    chk("refresh", mem_vec(), 10'b0_1_1_1_1_00101);
    bus_idle();

    io_out(16'h7FFF, 8'hC3);
    chk("m3_gpio", 10'(gpio), 10'h003);
    mem_chk("m3_rd_4000", 16'h4000, 1, 0, 0, 10'b0_1_1_1_1_00000);
    mem_chk("m3_rd_c000", 16'hC000, 1, 0, 0, 10'b1_0_1_0_1_00011);

    io_out(16'h7FF7, 8'hC4);
    chk("m4_gpio", 10'(gpio), 10'h044);
    dip = 4'b0011;
    mem_chk("m4_b8_rd_4000", 16'h4000, 1, 0, 0, 10'b1_1_0_0_1_00000);
    dip = 4'b0001;

    io_out(16'h7FFF, 8'hEA);
    chk("b5_gpio", 10'(gpio), 10'h02A);
    @(negedge CLK);
    A = 16'h8000; MREQ_B = 1'b0; RD_B = 1'b0;
    #1;
    chk("b5_rd_8000", mem_vec(), 10'b1_0_1_0_1_10110);
    #1;
    RESET_B = 1'b0;
    #1;
    chk("reset_midcycle", mem_vec(), 10'b0_1_1_1_1_00000);
    chk("reset_mid_gpio", 10'(gpio), 10'h000);
    bus_idle();
    #20;
    RESET_B = 1'b1;
    mem_chk("post_reset_rd", 16'h8000, 1, 0, 0, 10'b0_1_1_1_1_00000);
    chk("post_reset_gpio", 10'(gpio), 10'h000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
